// File: rtl/rs232_fifo_uart.sv
// RS-232 UART with independent TX/RX FIFOs, configurable character width, parity and bit period.
// The RX path samples each bit at its midpoint and stores parity/framing status alongside the data.
module rs232_fifo_uart #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY       = 0
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [$clog2(FIFO_DEPTH):0] tx_level,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        rx_parity_err,
    output logic                        rx_framing_err,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] rx_level,
    output logic                        rx_overrun,
    input  logic                        rs232_RXD,
    output logic                        rs232_TXD
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int EW = DATA_BITS + 2;
    localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY == 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        tx_wr_ptr, tx_rd_ptr;
    logic                 tx_push, tx_pop;

    assign tx_ready = (tx_level != FULL);
    assign tx_push  = tx_valid && tx_ready;

    always_ff @(posedge clk_clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            if (tx_push && !tx_pop)      tx_level <= tx_level + 1'b1;
            else if (!tx_push && tx_pop) tx_level <= tx_level - 1'b1;
        end
    end

    tx_state_t            tx_state, tx_state_next;
    logic [CW-1:0]        tx_cnt;
    logic [BW-1:0]        tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par, tx_line, tx_line_next, tx_shift_en, tx_bit_end;

    assign tx_bit_end = (tx_cnt == BIT_END);
    assign rs232_TXD  = tx_line;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) tx_state <= TX_IDLE;
        else             tx_state <= tx_state_next;
    end

    // The line level is registered so the next bit appears on the edge that ends the current one.
    always_comb begin
        tx_state_next = tx_state;
        tx_line_next  = tx_line;
        tx_pop        = 1'b0;
        tx_shift_en   = 1'b0;
        case (tx_state)
            TX_IDLE: if (tx_level != '0) begin
                tx_state_next = TX_START;
                tx_pop        = 1'b1;
                tx_line_next  = 1'b0;
            end
            TX_START: if (tx_bit_end) begin
                tx_state_next = TX_DATA;
                tx_line_next  = tx_shift[0];
            end
            TX_DATA: if (tx_bit_end) begin
                if (tx_bit != LAST_BIT) begin
                    tx_shift_en  = 1'b1;
                    tx_line_next = tx_shift[1];
                end else if (PARITY != 0) begin
                    tx_state_next = TX_PARITY;
                    tx_line_next  = tx_par;
                end else begin
                    tx_state_next = TX_STOP;
                    tx_line_next  = 1'b1;
                end
            end
            TX_PARITY: if (tx_bit_end) begin
                tx_state_next = TX_STOP;
                tx_line_next  = 1'b1;
            end
            TX_STOP: if (tx_bit_end) begin
                if (tx_level != '0) begin
                    tx_state_next = TX_START;
                    tx_pop        = 1'b1;
                    tx_line_next  = 1'b0;
                end else begin
                    tx_state_next = TX_IDLE;
                    tx_line_next  = 1'b1;
                end
            end
            default: begin
                tx_state_next = TX_IDLE;
                tx_line_next  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            tx_line  <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_line <= tx_line_next;
            if (tx_pop) begin
                tx_shift <= tx_mem[tx_rd_ptr];
                tx_par   <= (^tx_mem[tx_rd_ptr]) ^ ODD;
                tx_cnt   <= '0;
                tx_bit   <= '0;
            end else if (tx_state != TX_IDLE) begin
                if (tx_bit_end) begin
                    tx_cnt <= '0;
                    if (tx_shift_en) begin
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 1'b1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
        end
    end

    logic [1:0] rx_sync;
    logic       rx_prev, rx_s;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rs232_RXD};
            rx_prev <= rx_s;
        end
    end

    rx_state_t            rx_state, rx_state_next;
    logic [CW-1:0]        rx_cnt;
    logic [BW-1:0]        rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_err, rx_push, rx_bit_end;

    assign rx_bit_end = (rx_cnt == BIT_END);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) rx_state <= RX_IDLE;
        else             rx_state <= rx_state_next;
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_push       = 1'b0;
        case (rx_state)
            RX_IDLE:      if (rx_prev && !rx_s) rx_state_next = RX_START;
            RX_START:     if (rx_cnt == HALF_END) rx_state_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rx_bit_end && rx_bit == LAST_BIT)
                              rx_state_next = (PARITY != 0) ? RX_PARITY : RX_STOP;
            RX_PARITY:    if (rx_bit_end) rx_state_next = RX_STOP;
            RX_STOP:      if (rx_bit_end) begin
                rx_push       = 1'b1;
                rx_state_next = rx_s ? RX_IDLE : RX_WAIT_HIGH;
            end
            RX_WAIT_HIGH: if (rx_s) rx_state_next = RX_IDLE;
            default:      rx_state_next = RX_IDLE;
        endcase
    end

    // Counting restarts at the start-bit midpoint so every later sample lands mid-bit.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par_err <= 1'b0;
        end else begin
            case (rx_state)
                RX_START: begin
                    if (rx_cnt == HALF_END) begin
                        rx_cnt     <= '0;
                        rx_bit     <= '0;
                        rx_par_err <= 1'b0;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA, RX_PARITY, RX_STOP: begin
                    if (rx_bit_end) begin
                        rx_cnt <= '0;
                        if (rx_state == RX_DATA) begin
                            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                            rx_bit   <= rx_bit + 1'b1;
                        end
                        if (rx_state == RX_PARITY) rx_par_err <= rx_s ^ (^rx_shift) ^ ODD;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_cnt <= '0;
            endcase
        end
    end

    logic [EW-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic          rx_pop, rx_full, rx_write;

    assign rx_valid = (rx_level != '0);
    assign rx_full  = (rx_level == FULL);
    assign rx_pop   = rx_ready && rx_valid;
    assign rx_write = rx_push && (!rx_full || rx_pop);
    assign {rx_data, rx_parity_err, rx_framing_err} = rx_valid ? rx_mem[rx_rd_ptr] : '0;

    always_ff @(posedge clk_clk) begin
        if (rx_write) rx_mem[rx_wr_ptr] <= {rx_shift, rx_par_err, !rx_s};
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            rx_wr_ptr  <= '0;
            rx_rd_ptr  <= '0;
            rx_level   <= '0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= rx_push && rx_full && !rx_pop;
            if (rx_write) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)   rx_rd_ptr <= rx_rd_ptr + 1'b1;
            if (rx_write && !rx_pop)      rx_level <= rx_level + 1'b1;
            else if (!rx_write && rx_pop) rx_level <= rx_level - 1'b1;
        end
    end

endmodule

// File: doc/rs232_fifo_uart.md
RS232_FIFO_UART -- requirements
Module: rs232_fifo_uart

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning data bits per character; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 434, meaning clk_clk cycles per bit (50 MHz / 115200); legal minimum 8.
REQ-003 Parameter FIFO_DEPTH, default 16, meaning entries per TX and RX FIFO; power of two, legal range 2..256.
REQ-004 Parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 clk_clk  in  1  single clock, rising edge.
REQ-006 reset_reset  in  1  asynchronous, active-high reset.
REQ-007 tx_data  in  DATA_BITS  character to send.
REQ-008 tx_valid  in  1  write request.
REQ-009 tx_ready  out  1  TX FIFO not full.
REQ-010 tx_level  out  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy.
REQ-011 rx_data  out  DATA_BITS  head of RX FIFO.
REQ-012 rx_parity_err, rx_framing_err  out  1 each  flags stored with the head entry.
REQ-013 rx_valid  out  1  RX FIFO not empty.
REQ-014 rx_ready  in  1  pop request.
REQ-015 rx_level  out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy.
REQ-016 rx_overrun  out  1  one-cycle pulse, received character dropped.
REQ-017 rs232_RXD  in  1  serial input, asynchronous to clk_clk.
REQ-018 rs232_TXD  out  1  serial output, idle high.

Function
REQ-019 Transfer occurs on a rising edge where valid and ready are both high; tx_ready and rx_valid are functions of registered occupancy only.
REQ-020 Frame: one start bit (0), DATA_BITS data bits LSB first, parity bit only if PARITY!=0, one stop bit (1); every bit lasts exactly CLKS_PER_BIT cycles.
REQ-021 TX FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START pops the FIFO when it is non-empty; DATA->PARITY or STOP after DATA_BITS bits; PARITY->STOP; STOP->START directly if the FIFO is non-empty, else IDLE.
REQ-022 Latency: a word accepted into an empty TX FIFO with the FSM in IDLE at edge N drives rs232_TXD low from edge N+1.
REQ-023 Back-to-back characters have no idle gap between stop bit and next start bit.
REQ-024 Parity bit = XOR of data bits (even) or its inverse (odd).
REQ-025 rs232_RXD passes through a 2-flop synchroniser before any use.
REQ-026 RX FSM states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; falling edge in IDLE -> START.
REQ-027 START re-samples after CLKS_PER_BIT/2 cycles; if high, glitch, return to IDLE with no push.
REQ-028 Subsequent bits sampled every CLKS_PER_BIT cycles from the start midpoint.
REQ-029 At the stop sample the word plus parity_err and framing_err (stop sampled 0) is pushed; a framing error goes to WAIT_HIGH until the synchronised line is 1, then IDLE; otherwise IDLE.
REQ-030 Push into a full RX FIFO without a simultaneous pop drops the word and pulses rx_overrun for exactly one cycle; push and pop in the same cycle on a full FIFO both succeed, level unchanged.
REQ-031 Simultaneous push and pop on any FIFO leaves the level unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-032 Writes while tx_ready=0 and pops while rx_valid=0 are ignored with no state change.

Reset
REQ-033 On reset_reset asserted, immediately: both FSMs IDLE, FIFOs empty, rs232_TXD=1, tx_ready=1, tx_level=0, rx_valid=0, rx_level=0, rx_data=0, error flags=0, rx_overrun=0, synchroniser flops=1.
REQ-034 Reset mid-frame aborts the frame; an in-progress RX character is discarded and TX restarts cleanly from IDLE after release.

Verification
REQ-035 Defaults, write 0x55 into empty FIFO -> TXD low after next edge, bits 1,0,1,0,1,0,1,0 each 434 cycles, stop high, then idle.
REQ-036 PARITY=2, loop TXD to RXD, send 0x00,0xFF,0xA5 -> RX pops same bytes, parity_err=0, framing_err=0, no gaps between TX frames.
REQ-037 Drive RXD low for 100 cycles only -> no push, RX returns IDLE.
REQ-038 Drive frame 0x3C with stop bit 0 and line held low 2000 cycles -> entry 0x3C, framing_err=1, next frame received correctly after line goes high.
REQ-039 FIFO_DEPTH=4, receive 5 characters without popping -> rx_level=4, tx/rx first four intact, one rx_overrun pulse on fifth.
REQ-040 Assert reset_reset mid data bit of TX -> TXD=1 same cycle, tx_level=0, next write transmits complete frame.
